// File: rtl/adc_init_seq_if.sv
// ----------------------------------------------------------------------------
// adc_init_seq_if
//   Bundles the signals between the ADC power-up sequencer, the slow-control
//   tick generator and the per-ADC serial-config engines.
//
//   Sequencer inputs : SLOW_TICK (slow timebase strobe), REINIT (re-run
//                      request), INIT_DONE[N_ADC] (per-ADC config complete)
//   Sequencer outputs: ADC_RST, ADC_INIT[N_ADC], INC_TMR, RUN,
//                      FAIL_MASK[N_ADC], RETRY_CNT[8]
//
//   master : the sequencer side
//   slave  : the environment side (tick source, config engines, consumers)
// ----------------------------------------------------------------------------
interface adc_init_seq_if #(
    parameter int N_ADC = 4
);
    logic             SLOW_TICK;
    logic             REINIT;
    logic [N_ADC-1:0] INIT_DONE;
    logic             ADC_RST;
    logic [N_ADC-1:0] ADC_INIT;
    logic             INC_TMR;
    logic             RUN;
    logic [N_ADC-1:0] FAIL_MASK;
    logic [7:0]       RETRY_CNT;

    modport master (
        input  SLOW_TICK, REINIT, INIT_DONE,
        output ADC_RST, ADC_INIT, INC_TMR, RUN, FAIL_MASK, RETRY_CNT
    );

    modport slave (
        output SLOW_TICK, REINIT, INIT_DONE,
        input  ADC_RST, ADC_INIT, INC_TMR, RUN, FAIL_MASK, RETRY_CNT
    );
endinterface

// File: rtl/adc_init_seq.sv
// ----------------------------------------------------------------------------
// adc_init_seq
//   Power-up sequencer for N_ADC front-end ADCs: global ADC reset pulse,
//   then one-at-a-time init handshake with timeout and bounded retry, then a
//   settle wait, then RUN. REINIT in SETTLE/RUN restarts the whole sequence.
//
//   Ports
//     CLK  in  system clock
//     RST  in  asynchronous reset, active-high
//     bus  adc_init_seq_if.master
//            SLOW_TICK in  one-CLK strobe from slow timebase
//            REINIT    in  re-run sequence request (level)
//            INIT_DONE in  per-ADC config-complete (level)
//            ADC_RST   out global ADC reset pulse
//            ADC_INIT  out one-hot init request to the ADC being configured
//            INC_TMR   out high during settle wait
//            RUN       out sequence complete
//            FAIL_MASK out bit i set = ADC i exhausted its retries
//            RETRY_CNT out retries since last sequence start, saturating
// ----------------------------------------------------------------------------
module adc_init_seq #(
    parameter int N_ADC        = 4,
    parameter int PRE_DLY      = 6,
    parameter int RST_LEN      = 7,
    parameter int POST_DLY     = 5,
    parameter int INIT_TO      = 2000,
    parameter int MAX_RETRY    = 3,
    parameter int SETTLE_TICKS = 1000
) (
    input  logic          CLK,
    input  logic          RST,
    adc_init_seq_if.master bus
);
    localparam int IDX_W = (N_ADC > 1) ? $clog2(N_ADC) : 1;

    // Terminal values: each phase ends on the cycle its counter hits these.
    localparam logic [15:0]      PRE_END    = 16'(PRE_DLY - 1);
    localparam logic [15:0]      ARST_END   = 16'(RST_LEN - 1);
    localparam logic [15:0]      POST_END   = 16'(POST_DLY - 1);
    localparam logic [11:0]      INIT_END   = 12'(INIT_TO - 1);
    localparam logic [11:0]      SETTLE_END = 12'(SETTLE_TICKS - 1);
    localparam logic [3:0]       TRY_LIMIT  = 4'(MAX_RETRY);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_ADC - 1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_PRE    = 4'd1,
        S_ARST   = 4'd2,
        S_POST   = 4'd3,
        S_INIT   = 4'd4,
        S_DROP   = 4'd5,
        S_NEXT   = 4'd6,
        S_SETTLE = 4'd7,
        S_RUN    = 4'd8
    } state_t;

    state_t             r_state;
    logic [15:0]        r_cnt;
    logic [11:0]        r_tick;
    logic [3:0]         r_tries;
    logic [IDX_W-1:0]   r_idx;
    logic [N_ADC-1:0]   r_fail;
    logic [7:0]         r_retry;
    logic               r_adc_rst;
    logic [N_ADC-1:0]   r_adc_init;
    logic               r_inc_tmr;
    logic               r_run;

    state_t             w_nxt;
    logic [15:0]        w_cnt_nxt;
    logic [11:0]        w_tick_nxt;
    logic [3:0]         w_tries_nxt;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [N_ADC-1:0]   w_fail_nxt;
    logic [7:0]         w_retry_nxt;

    always_comb begin
        w_nxt       = r_state;
        w_cnt_nxt   = r_cnt + 16'd1;
        w_tick_nxt  = r_tick;
        w_tries_nxt = r_tries;
        w_idx_nxt   = r_idx;
        w_fail_nxt  = r_fail;
        w_retry_nxt = r_retry;
        case (r_state)
            S_IDLE: begin
                w_nxt       = S_PRE;
                w_cnt_nxt   = 16'd0;
                w_idx_nxt   = '0;
                w_tries_nxt = 4'd0;
                w_fail_nxt  = '0;
                w_retry_nxt = 8'd0;
            end
            S_PRE: begin
                if (r_cnt == PRE_END) begin
                    w_nxt     = S_ARST;
                    w_cnt_nxt = 16'd0;
                end
            end
            S_ARST: begin
                if (r_cnt == ARST_END) begin
                    w_nxt     = S_POST;
                    w_cnt_nxt = 16'd0;
                end
            end
            S_POST: begin
                if (r_cnt == POST_END) begin
                    w_nxt       = S_INIT;
                    w_idx_nxt   = '0;
                    w_tries_nxt = 4'd0;
                    w_tick_nxt  = 12'd0;
                end
            end
            S_INIT: begin
                // INIT_DONE is checked first so a completion on the timeout
                // tick is accepted rather than counted as a retry.
                if (bus.INIT_DONE[r_idx]) begin
                    w_nxt = S_NEXT;
                end else if (bus.SLOW_TICK) begin
                    if (r_tick == INIT_END) begin
                        if (r_tries < TRY_LIMIT) begin
                            w_nxt       = S_DROP;
                            w_tries_nxt = r_tries + 4'd1;
                            w_retry_nxt = (r_retry == 8'hFF) ? r_retry : r_retry + 8'd1;
                        end else begin
                            w_nxt             = S_NEXT;
                            w_fail_nxt[r_idx] = 1'b1;
                        end
                    end else begin
                        w_tick_nxt = r_tick + 12'd1;
                    end
                end
            end
            S_DROP: begin
                w_nxt      = S_INIT;
                w_tick_nxt = 12'd0;
            end
            S_NEXT: begin
                w_tick_nxt = 12'd0;
                if (r_idx == LAST_IDX) begin
                    w_nxt = S_SETTLE;
                end else begin
                    w_nxt       = S_INIT;
                    w_idx_nxt   = r_idx + 1'b1;
                    w_tries_nxt = 4'd0;
                end
            end
            S_SETTLE: begin
                if (bus.REINIT) begin
                    w_nxt = S_IDLE;
                end else if (bus.SLOW_TICK) begin
                    if (r_tick == SETTLE_END) begin
                        w_nxt = S_RUN;
                    end else begin
                        w_tick_nxt = r_tick + 12'd1;
                    end
                end
            end
            S_RUN: begin
                if (bus.REINIT) begin
                    w_nxt = S_IDLE;
                end
            end
            default: begin
                w_nxt = S_IDLE;
            end
        endcase
        // Status is per-sequence: wipe it as soon as a restart is decided.
        if (w_nxt == S_IDLE) begin
            w_fail_nxt  = '0;
            w_retry_nxt = 8'd0;
        end
    end

    // Outputs are decoded from the next state so they line up with the
    // cycle in which that state is entered.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_cnt      <= 16'd0;
            r_tick     <= 12'd0;
            r_tries    <= 4'd0;
            r_idx      <= '0;
            r_fail     <= '0;
            r_retry    <= 8'd0;
            r_adc_rst  <= 1'b0;
            r_adc_init <= '0;
            r_inc_tmr  <= 1'b0;
            r_run      <= 1'b0;
        end else begin
            r_state    <= w_nxt;
            r_cnt      <= w_cnt_nxt;
            r_tick     <= w_tick_nxt;
            r_tries    <= w_tries_nxt;
            r_idx      <= w_idx_nxt;
            r_fail     <= w_fail_nxt;
            r_retry    <= w_retry_nxt;
            r_adc_rst  <= (w_nxt == S_ARST);
            r_adc_init <= (w_nxt == S_INIT) ? (N_ADC'(1) << w_idx_nxt) : '0;
            r_inc_tmr  <= (w_nxt == S_SETTLE);
            r_run      <= (w_nxt == S_RUN);
        end
    end

    assign bus.ADC_RST   = r_adc_rst;
    assign bus.ADC_INIT  = r_adc_init;
    assign bus.INC_TMR   = r_inc_tmr;
    assign bus.RUN       = r_run;
    assign bus.FAIL_MASK = r_fail;
    assign bus.RETRY_CNT = r_retry;

endmodule

// File: tb/tb_adc_init_seq.sv
// ----------------------------------------------------------------------------
// tb_adc_init_seq
//   Directed bench for adc_init_seq with default parameters (N_ADC=4,
//   PRE_DLY=6, RST_LEN=7, POST_DLY=5, INIT_TO=2000, MAX_RETRY=3,
//   SETTLE_TICKS=1000). Inputs change 1 time unit after the rising edge and
//   outputs are sampled there; "edge k" below counts rising edges after the
//   reference point named in each step.
// ----------------------------------------------------------------------------
module tb_adc_init_seq;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    adc_init_seq_if #(.N_ADC(4)) bus ();

    adc_init_seq dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.master)
    );

    always #5 CLK = ~CLK;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bounded wait for a given ADC_INIT pattern; an expired budget shows up
    // as a failed comparison.
    task automatic wait_init(input string tag, input logic [3:0] val, input int limit);
        int k = 0;
        while (bus.ADC_INIT !== val && k < limit) begin
            step(1);
            k++;
        end
        chk(tag, 32'(bus.ADC_INIT), 32'(val));
    endtask

    task automatic wait_run(input string tag, input int limit);
        int k = 0;
        while (bus.RUN !== 1'b1 && k < limit) begin
            step(1);
            k++;
        end
        chk(tag, 32'(bus.RUN), 1);
    endtask

    logic [3:0] exp_init [8];

    initial begin
        exp_init = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0};
        bus.SLOW_TICK = 1'b0;
        bus.REINIT    = 1'b0;
        bus.INIT_DONE = 4'hF;

        // ---- Reset state ----
        step(3);
        chk("rst_adc_rst",   32'(bus.ADC_RST),   0);
        chk("rst_adc_init",  32'(bus.ADC_INIT),  0);
        chk("rst_run",       32'(bus.RUN),       0);
        chk("rst_inc_tmr",   32'(bus.INC_TMR),   0);
        chk("rst_fail_mask", 32'(bus.FAIL_MASK), 0);
        chk("rst_retry_cnt", 32'(bus.RETRY_CNT), 0);
        RST = 1'b0;

        // ---- Nominal sequence, INIT_DONE all high, no ticks yet ----
        step(6);
        chk("nom_adc_rst_e6",  32'(bus.ADC_RST), 0);
        step(1);
        chk("nom_adc_rst_e7",  32'(bus.ADC_RST), 1);
        step(6);
        chk("nom_adc_rst_e13", 32'(bus.ADC_RST), 1);
        step(1);
        chk("nom_adc_rst_e14", 32'(bus.ADC_RST), 0);
        step(4);
        chk("nom_adc_init_e18", 32'(bus.ADC_INIT), 0);
        for (int i = 0; i < 8; i++) begin
            step(1);
            chk($sformatf("nom_adc_init_e%0d", 19 + i), 32'(bus.ADC_INIT), 32'(exp_init[i]));
        end
        step(1);
        chk("nom_inc_tmr_e27", 32'(bus.INC_TMR), 1);
        chk("nom_run_e27",     32'(bus.RUN),     0);
        bus.SLOW_TICK = 1'b1;
        step(999);
        chk("nom_run_tick999",     32'(bus.RUN),     0);
        chk("nom_inc_tmr_tick999", 32'(bus.INC_TMR), 1);
        step(1);
        chk("nom_run_tick1000",     32'(bus.RUN),       1);
        chk("nom_inc_tmr_tick1000", 32'(bus.INC_TMR),   0);
        chk("nom_fail_mask",        32'(bus.FAIL_MASK), 0);
        chk("nom_retry_cnt",        32'(bus.RETRY_CNT), 0);

        // ---- ADC1 done only after 2500 ticks: one retry ----
        bus.INIT_DONE = 4'b1101;
        bus.REINIT = 1'b1;
        step(1);
        bus.REINIT = 1'b0;
        chk("late_run_drop", 32'(bus.RUN), 0);
        wait_init("late_wait_adc1", 4'h2, 100);
        step(1999);
        chk("late_init_t1999",  32'(bus.ADC_INIT),  4'h2);
        chk("late_retry_t1999", 32'(bus.RETRY_CNT), 0);
        step(1);
        chk("late_drop_init",  32'(bus.ADC_INIT),  0);
        chk("late_drop_retry", 32'(bus.RETRY_CNT), 1);
        step(1);
        chk("late_reinit_adc1", 32'(bus.ADC_INIT), 4'h2);
        step(499);
        bus.INIT_DONE = 4'hF;
        step(1);
        chk("late_next_init", 32'(bus.ADC_INIT), 0);
        wait_run("late_run", 1200);
        chk("late_fail_mask", 32'(bus.FAIL_MASK), 0);
        chk("late_retry_cnt", 32'(bus.RETRY_CNT), 1);

        // ---- ADC2 never done: 4 attempts, then marked failed ----
        bus.INIT_DONE = 4'b1011;
        bus.REINIT = 1'b1;
        step(1);
        bus.REINIT = 1'b0;
        wait_init("never_wait_adc2", 4'h4, 100);
        step(2000);
        chk("never_drop1_init",  32'(bus.ADC_INIT),  0);
        chk("never_drop1_retry", 32'(bus.RETRY_CNT), 1);
        step(2001);
        chk("never_drop2_retry", 32'(bus.RETRY_CNT), 2);
        step(2001);
        chk("never_drop3_retry", 32'(bus.RETRY_CNT), 3);
        chk("never_drop3_init",  32'(bus.ADC_INIT),  0);
        step(2000);
        chk("never_last_try_init", 32'(bus.ADC_INIT),  4'h4);
        chk("never_last_try_fail", 32'(bus.FAIL_MASK), 0);
        step(1);
        chk("never_fail_mask_set", 32'(bus.FAIL_MASK), 4'h4);
        chk("never_next_init",     32'(bus.ADC_INIT),  0);
        chk("never_retry_final",   32'(bus.RETRY_CNT), 3);
        step(1);
        chk("never_adc3_init", 32'(bus.ADC_INIT), 4'h8);
        wait_run("never_run", 1200);
        chk("never_run_fail_mask", 32'(bus.FAIL_MASK), 4'h4);
        chk("never_run_retry_cnt", 32'(bus.RETRY_CNT), 3);

        // ---- REINIT in RUN: restart, status cleared ----
        bus.INIT_DONE = 4'b1110;
        bus.REINIT = 1'b1;
        step(1);
        bus.REINIT = 1'b0;
        chk("reinit_run_drop",     32'(bus.RUN),     0);
        chk("reinit_inc_tmr_drop", 32'(bus.INC_TMR), 0);
        step(7);
        chk("reinit_adc_rst",   32'(bus.ADC_RST),   1);
        chk("reinit_fail_mask", 32'(bus.FAIL_MASK), 0);
        chk("reinit_retry_cnt", 32'(bus.RETRY_CNT), 0);

        // ---- REINIT ignored in INIT; done on the 2000th tick wins ----
        wait_init("tie_wait_adc0", 4'h1, 100);
        step(100);
        bus.REINIT = 1'b1;
        step(1);
        bus.REINIT = 1'b0;
        chk("ign_reinit_init",    32'(bus.ADC_INIT), 4'h1);
        chk("ign_reinit_adc_rst", 32'(bus.ADC_RST),  0);
        step(1898);
        chk("tie_init_t1999", 32'(bus.ADC_INIT), 4'h1);
        bus.INIT_DONE = 4'hF;
        step(1);
        chk("tie_next_init",  32'(bus.ADC_INIT),  0);
        chk("tie_retry_cnt",  32'(bus.RETRY_CNT), 0);
        step(1);
        chk("tie_adc1_init",  32'(bus.ADC_INIT),  4'h2);
        wait_run("tie_run", 1200);
        chk("tie_run_fail_mask", 32'(bus.FAIL_MASK), 0);

        // ---- RST mid-ARST: immediate abort, full timing restarts ----
        bus.REINIT = 1'b1;
        step(1);
        bus.REINIT = 1'b0;
        step(7);
        chk("abort_adc_rst_before", 32'(bus.ADC_RST), 1);
        step(2);
        #2;
        RST = 1'b1;
        #1;
        chk("abort_adc_rst_async", 32'(bus.ADC_RST), 0);
        step(2);
        chk("abort_run_in_rst", 32'(bus.RUN), 0);
        RST = 1'b0;
        step(6);
        chk("abort_adc_rst_e6",  32'(bus.ADC_RST), 0);
        step(1);
        chk("abort_adc_rst_e7",  32'(bus.ADC_RST), 1);
        step(6);
        chk("abort_adc_rst_e13", 32'(bus.ADC_RST), 1);
        step(1);
        chk("abort_adc_rst_e14", 32'(bus.ADC_RST), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
